// File: rtl/dof_stage.sv
// Decode-and-operand-fetch stage: decodes IR, reads the 32x32 register file, raises hazard stalls.
// Optional macro DOF_BYPASS_EN forwards a same-cycle WB write into the operand reads.
module dof_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      IR,
   input  logic [WIDTH-1:0] PC_in,
   input  logic             wb_RW,
   input  logic [4:0]       wb_DA,
   input  logic [WIDTH-1:0] wb_D,
   input  logic [1:0]       pcsrc,
   output logic             stall,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] PC,
   output logic             RW,
   output logic             MW,
   output logic             PS,
   output logic [4:0]       DA,
   output logic [4:0]       FS,
   output logic [4:0]       SH,
   output logic [1:0]       BS,
   output logic [1:0]       MD
);

   localparam logic [6:0] OP_ADD = 7'b0000010;
   localparam logic [6:0] OP_SUB = 7'b0000101;
   localparam logic [6:0] OP_AND = 7'b0001000;
   localparam logic [6:0] OP_OR  = 7'b0001010;
   localparam logic [6:0] OP_LSL = 7'b0001110;
   localparam logic [6:0] OP_LSR = 7'b0010000;
   localparam logic [6:0] OP_ADI = 7'b0100010;
   localparam logic [6:0] OP_LD  = 7'b0100001;
   localparam logic [6:0] OP_ST  = 7'b0000011;
   localparam logic [6:0] OP_BZ  = 7'b0100000;
   localparam logic [6:0] OP_BNZ = 7'b1100000;
   localparam logic [6:0] OP_JMP = 7'b1000100;

   typedef enum logic [1:0] {B_ZERO, B_REG, B_ZEXT, B_SEXT} bsel_t;

   logic [6:0]  op;
   logic [4:0]  dr, sa, sb;
   logic [14:0] imm;

   assign op  = IR[31:25];
   assign dr  = IR[24:20];
   assign sa  = IR[19:15];
   assign sb  = IR[14:10];
   assign imm = IR[14:0];

   logic       dec_rw, dec_mw, dec_ps, is_shift, uses_sa, uses_sb;
   logic [4:0] dec_fs;
   logic [1:0] dec_bs, dec_md;
   bsel_t      b_sel;

   always_comb begin
      dec_rw   = 1'b0;
      dec_mw   = 1'b0;
      dec_ps   = 1'b0;
      dec_fs   = 5'b00000;
      dec_bs   = 2'b00;
      dec_md   = 2'b00;
      is_shift = 1'b0;
      uses_sa  = 1'b0;
      uses_sb  = 1'b0;
      b_sel    = B_ZERO;
      case (op)
         OP_ADD: begin dec_fs = 5'b00010; b_sel = B_REG; dec_rw = 1'b1; uses_sa = 1'b1; uses_sb = 1'b1; end
         OP_SUB: begin dec_fs = 5'b00101; b_sel = B_REG; dec_rw = 1'b1; uses_sa = 1'b1; uses_sb = 1'b1; end
         OP_AND: begin dec_fs = 5'b01000; b_sel = B_REG; dec_rw = 1'b1; uses_sa = 1'b1; uses_sb = 1'b1; end
         OP_OR:  begin dec_fs = 5'b01010; b_sel = B_REG; dec_rw = 1'b1; uses_sa = 1'b1; uses_sb = 1'b1; end
         OP_LSL: begin dec_fs = 5'b10000; dec_rw = 1'b1; is_shift = 1'b1; uses_sa = 1'b1; end
         OP_LSR: begin dec_fs = 5'b10001; dec_rw = 1'b1; is_shift = 1'b1; uses_sa = 1'b1; end
         OP_ADI: begin dec_fs = 5'b00010; b_sel = B_ZEXT; dec_rw = 1'b1; uses_sa = 1'b1; end
         OP_LD:  begin dec_rw = 1'b1; dec_md = 2'b01; uses_sa = 1'b1; end
         OP_ST:  begin b_sel = B_REG; dec_mw = 1'b1; uses_sa = 1'b1; uses_sb = 1'b1; end
         OP_BZ:  begin b_sel = B_SEXT; dec_bs = 2'b01; uses_sa = 1'b1; end
         OP_BNZ: begin b_sel = B_SEXT; dec_bs = 2'b01; dec_ps = 1'b1; uses_sa = 1'b1; end
         OP_JMP: begin b_sel = B_SEXT; dec_bs = 2'b10; end
         default: ;
      endcase
   end

   logic [WIDTH-1:0] regs [32];
   logic             wb_hit_sa, wb_hit_sb;
   logic [WIDTH-1:0] rd_a, rd_b, op_b;

   assign wb_hit_sa = wb_RW && (wb_DA != 5'd0) && (wb_DA == sa);
   assign wb_hit_sb = wb_RW && (wb_DA != 5'd0) && (wb_DA == sb);

   // R0 is hardwired to zero on reads regardless of what was attempted to be written there.
   always_comb begin
      rd_a = (sa == 5'd0) ? '0 : regs[sa];
      rd_b = (sb == 5'd0) ? '0 : regs[sb];
`ifdef DOF_BYPASS_EN
      if (wb_hit_sa) rd_a = wb_D;
      if (wb_hit_sb) rd_b = wb_D;
`endif
      case (b_sel)
         B_REG:   op_b = rd_b;
         B_ZEXT:  op_b = {{(WIDTH-15){1'b0}}, imm};
         B_SEXT:  op_b = {{(WIDTH-15){imm[14]}}, imm};
         default: op_b = '0;
      endcase
   end

   logic ex_hazard, wb_hazard, flush;

   assign ex_hazard = RW && (DA != 5'd0) &&
                      ((uses_sa && (DA == sa)) || (uses_sb && (DA == sb)));
`ifdef DOF_BYPASS_EN
   assign wb_hazard = 1'b0;
`else
   assign wb_hazard = (uses_sa && wb_hit_sa) || (uses_sb && wb_hit_sb);
`endif
   assign flush = (pcsrc != 2'b00);
   assign stall = (ex_hazard || wb_hazard) && !flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (wb_RW && (wb_DA != 5'd0)) begin
         regs[wb_DA] <= wb_D;
      end
   end

   // A bubble still carries PC_in so EX sees a consistent PC for the slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         A  <= '0;
         B  <= '0;
         PC <= '0;
         RW <= 1'b0;
         MW <= 1'b0;
         PS <= 1'b0;
         DA <= 5'd0;
         FS <= 5'd0;
         SH <= 5'd0;
         BS <= 2'b00;
         MD <= 2'b00;
      end else if (flush || stall) begin
         A  <= '0;
         B  <= '0;
         PC <= PC_in;
         RW <= 1'b0;
         MW <= 1'b0;
         PS <= 1'b0;
         DA <= 5'd0;
         FS <= 5'd0;
         SH <= 5'd0;
         BS <= 2'b00;
         MD <= 2'b00;
      end else begin
         A  <= rd_a;
         B  <= op_b;
         PC <= PC_in;
         RW <= dec_rw;
         MW <= dec_mw;
         PS <= dec_ps;
         DA <= dec_rw ? dr : 5'd0;
         FS <= dec_fs;
         SH <= is_shift ? IR[4:0] : 5'd0;
         BS <= dec_bs;
         MD <= dec_md;
      end
   end

endmodule
